// File: rtl/if_prefetch_pkg.sv
// Shared types and default parameters for the instruction-fetch front end.
// Every other if_prefetch file imports this package.
package if_prefetch_pkg;

    localparam int unsigned IROM_ADDR_W = 14;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam int unsigned IF_DEPTH    = 4;

    // One buffered fetch result: 64 bits wide, with the PC in the upper half.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // What the PC does at the end of the current cycle.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_ISSUE,
        OP_REDIRECT
    } fetch_op_e;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of the IROM, redirect and ID-handshake signals for the fetch front end.
// The master side is the prefetch unit; the slave side is IROM plus the pipeline.
interface if_prefetch_if
    import if_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W = IROM_ADDR_W,
    parameter int unsigned DEPTH  = IF_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output inst_addr,
        input  inst,
        input  redirect,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_inst,
        output fifo_count
    );

    modport slave (
        input  inst_addr,
        output inst,
        output redirect,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_inst,
        input  fifo_count
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO that holds {pc, inst} entries for the prefetch queue.
// Flush wins over push and pop, and pointers wrap modulo DEPTH (a power of 2).
module if_fifo
    import if_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // The guards are only a safety net: the fetch credit already rules out overflow.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, issues one IROM read per cycle and
// queues the {pc, inst} results for ID. A redirect flushes all in-flight and queued work.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = IROM_ADDR_W,
    parameter int unsigned DEPTH    = IF_DEPTH,
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    if_prefetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    fetch_op_e        fetch_op;
    logic             pop;
    logic             push;
    logic             flush;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    if_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .empty    (empty),
        .count    (count)
    );

    assign bus.inst_addr  = fetch_pc_q[ADDR_W+1:2];
    assign bus.id_valid   = !empty;
    assign bus.id_pc      = head.pc;
    assign bus.id_inst    = head.inst;
    assign bus.fifo_count = count;

    // The outstanding IROM response counts against the queue space, so a
    // response never lands in a full queue. The redirect overrides everything.
    always_comb begin
        pop         = !empty && bus.id_ready;
        credit_used = {1'b0, count} - (CNT_W+1)'(pop) + (CNT_W+1)'(inflight_q);

        if (bus.redirect) begin
            fetch_op = OP_REDIRECT;
        end else if (credit_used < (CNT_W+1)'(DEPTH)) begin
            fetch_op = OP_ISSUE;
        end else begin
            fetch_op = OP_HOLD;
        end

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        case (fetch_op)
            OP_REDIRECT: fetch_pc_d = word_align(bus.redirect_pc);
            OP_ISSUE: begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            default: fetch_pc_d = fetch_pc_q;
        endcase

        flush          = bus.redirect;
        push           = inflight_q && !bus.redirect;
        push_data.pc   = inflight_pc_q;
        push_data.inst = bus.inst;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a DEPTH=4 unit is checked against a queue-level reference model,
// and a DEPTH=2 unit with random id_ready is checked by an in-order scoreboard.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int unsigned AW       = 14;
    localparam logic [31:0] RST_PC_A = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_if #(.ADDR_W(AW), .DEPTH(4)) bus_a ();
    if_prefetch_if #(.ADDR_W(AW), .DEPTH(2)) bus_b ();

    if_prefetch #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(RST_PC_A)) dut_a (
        .cpu_clk(clk),
        .cpu_rst(rst),
        .bus    (bus_a.master)
    );

    if_prefetch #(.ADDR_W(AW), .DEPTH(2), .RESET_PC(RST_PC_B)) dut_b (
        .cpu_clk(clk),
        .cpu_rst(rst),
        .bus    (bus_b.master)
    );

    // IROM word n holds the value n, returned one cycle after the address.
    always @(posedge clk) begin
        bus_a.inst <= 32'(bus_a.inst_addr);
        bus_b.inst <= 32'(bus_b.inst_addr);
    end

    int          tests = 0;
    int          fails = 0;
    bit          model_live = 1'b0;
    logic [31:0] m_pc = RST_PC_A;
    bit          m_inf = 1'b0;
    logic [31:0] m_inf_pc = 32'h0;
    logic [31:0] m_q[$];
    logic [31:0] exp_b = RST_PC_B;
    int          b_accepted = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc >> 2) & ((32'd1 << AW) - 32'd1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit redir, input logic [31:0] rpc, input bit rdy);
        rst               = r;
        bus_a.redirect    = redir;
        bus_a.redirect_pc = rpc;
        bus_a.id_ready    = rdy;
        bus_b.redirect    = 1'b0;
        bus_b.redirect_pc = 32'h0;
        bus_b.id_ready    = 1'($urandom_range(0, 1));
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        if (model_live) begin
            checkOutput("a_valid", 32'(bus_a.id_valid), 32'(m_q.size() != 0));
            checkOutput("a_count", 32'(bus_a.fifo_count), 32'(m_q.size()));
            checkOutput("a_inst_addr", 32'(bus_a.inst_addr), word_of(m_pc));
            if (m_q.size() != 0) begin
                checkOutput("a_id_pc", bus_a.id_pc, m_q[0]);
                checkOutput("a_id_inst", bus_a.id_inst, word_of(m_q[0]));
            end
            checkOutput("b_count_bound", 32'(bus_b.fifo_count > 2), 32'h0);
            checkOutput("b_valid_vs_count", 32'(bus_b.id_valid), 32'(bus_b.fifo_count != 0));
            if (bus_b.id_valid && bus_b.id_ready) begin
                checkOutput("b_order_pc", bus_b.id_pc, exp_b);
                checkOutput("b_order_inst", bus_b.id_inst, word_of(exp_b));
                exp_b = exp_b + 32'd4;
                b_accepted++;
            end
        end
    endtask

    // Reference model of the queue: entries appear one cycle after their fetch,
    // and a fetch is allowed only while queue plus outstanding response fits.
    task automatic endCycle();
        bit pop;
        bit issue;
        int used;
        @(posedge clk);
        if (rst) begin
            m_pc       = RST_PC_A;
            m_inf      = 1'b0;
            m_q.delete();
            exp_b      = RST_PC_B;
            model_live = 1'b1;
        end else if (bus_a.redirect) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = bus_a.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            pop   = (m_q.size() != 0) && bus_a.id_ready;
            used  = m_q.size() - int'(pop) + int'(m_inf);
            issue = (used < 4);
            if (pop) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
            if (issue) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
            m_inf = issue;
        end
        #1;
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            sampleCycle();
            endCycle();
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Streaming from reset, then a redirect to 0x100 at cycle 10.
        doReset(2);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, c == 10, 32'h100, 1'b1);
            sampleCycle();
            if (c == 1) checkOutput("s1_not_yet_valid", 32'(bus_a.id_valid), 32'h0);
            if (c == 2) begin
                checkOutput("s1_first_valid", 32'(bus_a.id_valid), 32'h1);
                checkOutput("s1_first_pc", bus_a.id_pc, RST_PC_A);
            end
            if (c == 5) begin
                checkOutput("s1_pc_c5", bus_a.id_pc, 32'hC);
                checkOutput("s1_inst_c5", bus_a.id_inst, 32'h3);
            end
            if (c == 11 || c == 12) checkOutput("s1_redir_bubble", 32'(bus_a.id_valid), 32'h0);
            if (c == 13) begin
                checkOutput("s1_redir_pc", bus_a.id_pc, 32'h100);
                checkOutput("s1_redir_inst", bus_a.id_inst, 32'h40);
            end
            if (c == 14) checkOutput("s1_redir_next", bus_a.id_pc, 32'h104);
            endCycle();
        end

        // id_ready low from cycle 0: queue saturates, then drains gap-free.
        doReset(1);
        for (int c = 0; c < 14; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, c >= 8);
            sampleCycle();
            if (c == 7) begin
                checkOutput("s2_full_count", 32'(bus_a.fifo_count), 32'h4);
                checkOutput("s2_addr_frozen", 32'(bus_a.inst_addr), 32'h4);
            end
            if (c >= 8 && c <= 12) begin
                checkOutput("s2_drain_valid", 32'(bus_a.id_valid), 32'h1);
                checkOutput("s2_drain_pc", bus_a.id_pc, 32'((c - 8) * 4));
            end
            endCycle();
        end

        // Unaligned redirect, then back-to-back redirects where the last one wins.
        doReset(1);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, (c == 4) || (c == 10) || (c == 11),
                          (c == 4) ? 32'h203 : ((c == 10) ? 32'h100 : 32'h300), 1'b1);
            sampleCycle();
            if (c == 7) begin
                checkOutput("s3_align_pc", bus_a.id_pc, 32'h200);
                checkOutput("s3_align_inst", bus_a.id_inst, 32'h80);
            end
            if (c == 8) checkOutput("s3_align_next", bus_a.id_pc, 32'h204);
            if (c >= 11 && c <= 13) checkOutput("s3_b2b_bubble", 32'(bus_a.id_valid), 32'h0);
            if (c == 14) begin
                checkOutput("s3_b2b_valid", 32'(bus_a.id_valid), 32'h1);
                checkOutput("s3_b2b_pc", bus_a.id_pc, 32'h300);
                checkOutput("s3_b2b_inst", bus_a.id_inst, 32'hC0);
            end
            endCycle();
        end

        // One-cycle reset while the queue is full.
        doReset(1);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            sampleCycle();
            endCycle();
        end
        doReset(1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            sampleCycle();
            if (c == 0) begin
                checkOutput("s4_rst_valid", 32'(bus_a.id_valid), 32'h0);
                checkOutput("s4_rst_count", 32'(bus_a.fifo_count), 32'h0);
            end
            if (c == 2) begin
                checkOutput("s4_rst_first_valid", 32'(bus_a.id_valid), 32'h1);
                checkOutput("s4_rst_first_pc", bus_a.id_pc, RST_PC_A);
            end
            endCycle();
        end

        // PC wraps silently past the top of the address space.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, c == 0, 32'hFFFF_FFF8, 1'b1);
            sampleCycle();
            if (c == 3) checkOutput("s5_wrap_hi", bus_a.id_pc, 32'hFFFF_FFF8);
            if (c == 5) begin
                checkOutput("s5_wrap_pc", bus_a.id_pc, 32'h0);
                checkOutput("s5_wrap_inst", bus_a.id_inst, 32'h0);
            end
            endCycle();
        end

        // Random ready, redirects and occasional resets against the model.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0,
                          $urandom, $urandom_range(0, 3) != 0);
            sampleCycle();
            endCycle();
        end

        checkOutput("b_progress", 32'(b_accepted >= 40), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
